weight_pingpong_buffer: RTL

- Parametrised, double-banked successor of the single-bank weight buffer. It sits between the DMA write stream and the conv/GEMM weight fetch port.
- While the compute engine reads one bank, the DMA fills the other. Banks swap under a per-bank ownership state machine, so weight loading overlaps compute.
- Each bank records the word count of its last fill.

---
 rtl/weight_pingpong_buffer_pkg.sv | 11 +
 rtl/wpb_bank_ram.sv | 22 ++
 rtl/weight_pingpong_buffer.sv | 90 +++++++++
 3 files changed

// File: rtl/weight_pingpong_buffer_pkg.sv
// weight_pingpong_buffer_pkg: bank ownership encodings and default sizing for the ping-pong weight buffer
package weight_pingpong_buffer_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } bank_st_e;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH = 1024;
endpackage

// File: rtl/wpb_bank_ram.sv
// wpb_bank_ram: single-port synchronous RAM; dout only updates on a read so it holds between reads
module wpb_bank_ram
  import weight_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= din;
      else dout <= mem[addr];
    end
endmodule

// File: rtl/weight_pingpong_buffer.sv
// weight_pingpong_buffer: two weight banks swapped by per-bank ownership state so DMA fill overlaps compute reads
module weight_pingpong_buffer
  import weight_pingpong_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  input  logic                  w_last,
  output logic                  w_ready,
  input  logic                  conv_en,
  input  logic                  w_done,
  input  logic [ADDR_W-1:0]     weight_addr,
  input  logic                  w_addr_vld,
  output logic [DATA_WIDTH-1:0] weight_data,
  output logic                  weight_vld,
  output logic [ADDR_W:0]       rd_bank_len,
  output logic [1:0]            bank_full,
  output logic                  len_err
);
  bank_st_e st_q [2];
  bank_st_e st_d [2];
  logic wr_ptr, rd_ptr, claim_ptr, rd_sel, rd_seen;
  logic wr_fire, wr_close, rd_issue, rel, claim;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0] len_q [2];
  logic [DATA_WIDTH-1:0] ram_dout [2];
  assign w_ready = rstn && enable && (st_q[wr_ptr] == ST_EMPTY || st_q[wr_ptr] == ST_FILLING);
  assign wr_fire = w_valid && w_ready;
  assign wr_close = wr_fire && (w_last || wr_addr == ADDR_W'(DEPTH - 1));
  assign rd_issue = w_addr_vld && enable && st_q[rd_ptr] == ST_READING;
  assign rel = w_done && st_q[rd_ptr] == ST_READING;
  // a release hands the claim over to the other bank in the same edge
  assign claim_ptr = rd_ptr ^ rel;
  assign claim = enable && conv_en && st_q[claim_ptr] == ST_FULL;
  assign bank_full = {st_q[1] inside {ST_FULL, ST_READING}, st_q[0] inside {ST_FULL, ST_READING}};
  assign rd_bank_len = st_q[rd_ptr] == ST_READING ? len_q[rd_ptr] : '0;
  assign weight_data = rd_seen ? ram_dout[rd_sel] : '0;
  always_comb begin
    st_d = st_q;
    if (wr_fire) st_d[wr_ptr] = wr_close ? ST_FULL : ST_FILLING;
    if (rel) st_d[rd_ptr] = ST_EMPTY;
    if (claim) st_d[claim_ptr] = ST_READING;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      st_q <= '{ST_EMPTY, ST_EMPTY};
      len_q <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      wr_addr <= '0;
      len_err <= 1'b0;
      weight_vld <= 1'b0;
      rd_seen <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      st_q <= st_d;
      if (wr_fire) wr_addr <= wr_close ? '0 : wr_addr + ADDR_W'(1);
      if (wr_close) begin
        len_q[wr_ptr] <= {1'b0, wr_addr} + (ADDR_W + 1)'(1);
        wr_ptr <= ~wr_ptr;
      end
      if (wr_close && !w_last) len_err <= 1'b1;
      if (rel) rd_ptr <= ~rd_ptr;
      weight_vld <= rd_issue;
      if (rd_issue) begin
        rd_seen <= 1'b1;
        rd_sel <= rd_ptr;
      end
    end
  // the two banks are never written and read at once, so each RAM port muxes its address by owner
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic we, en;
    assign we = wr_fire && wr_ptr == 1'(b);
    assign en = we || (rd_issue && rd_ptr == 1'(b));
    wpb_bank_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk(clk),
      .en(en),
      .we(we),
      .addr(we ? wr_addr : weight_addr),
      .din(w_data),
      .dout(ram_dout[b])
    );
  end
endmodule
